phys_reg_free_list: RTL

- Parametrised physical-register free list for the rename stage.
- Supersedes fixed 6-bit physical addressing with configurable register-file size and superscalar width.
- Circular FIFO of free physical tags. Supplies up to WIDTH new rd tags per cycle to rename/dispatch.
- Accepts up to WIDTH freed rd_old tags per cycle from ROB retire.

---
 rtl/phys_reg_free_list_if.sv | 24 ++
 rtl/phys_reg_free_list.sv | 79 +++++++
 2 files changed

// File: rtl/phys_reg_free_list_if.sv
// Rename-side handshake for the physical register free list: alloc group, release group, status.
interface phys_reg_free_list_if #(
    parameter int WIDTH  = 2,
    parameter int PREG_W = 6,
    parameter int CNT_W  = 6
);
    logic [WIDTH-1:0]        alloc_req;
    logic                    alloc_ready;
    logic [WIDTH*PREG_W-1:0] alloc_preg;
    logic [WIDTH-1:0]        rel_valid;
    logic [WIDTH*PREG_W-1:0] rel_preg;
    logic [CNT_W-1:0]        free_count;
    logic                    empty;
    logic                    overflow_err;

    modport master (
        output alloc_req, rel_valid, rel_preg,
        input  alloc_ready, alloc_preg, free_count, empty, overflow_err
    );
    modport slave (
        input  alloc_req, rel_valid, rel_preg,
        output alloc_ready, alloc_preg, free_count, empty, overflow_err
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical tags: up to WIDTH compacted allocs and releases per cycle.
module phys_reg_free_list #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int WIDTH    = 2,
    parameter int PREG_W   = $clog2(NUM_PHYS)
) (
    input  logic               clk,
    input  logic               reset,
    phys_reg_free_list_if.slave fl
);
    localparam int DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LN_W  = $clog2(WIDTH + 1);

    logic [PREG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              ovf_q;

    logic [LN_W-1:0]              alloc_n, rel_n;
    logic [WIDTH-1:0]             rel_ok;
    logic [WIDTH-1:0][PTR_W-1:0]  wr_idx;
    logic [WIDTH-1:0][PREG_W-1:0] rel_tag;
    logic [CNT_W:0]               rel_sum;
    logic                         fire, rel_drop, rel_go;
    logic [CNT_W-1:0]             pop_n, push_n;

    // Lane i reads/writes at pointer + number of active lanes below it.
    always_comb begin
        alloc_n       = '0;
        rel_n         = '0;
        fl.alloc_preg = '0;
        rel_ok        = '0;
        wr_idx        = '0;
        rel_tag       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fl.alloc_preg[i*PREG_W +: PREG_W] = mem[head + PTR_W'(alloc_n)];
            if (fl.alloc_req[i]) alloc_n = alloc_n + 1'b1;
            rel_tag[i] = fl.rel_preg[i*PREG_W +: PREG_W];
            rel_ok[i]  = fl.rel_valid[i] && (rel_tag[i] != '0);
            wr_idx[i]  = tail + PTR_W'(rel_n);
            if (rel_ok[i]) rel_n = rel_n + 1'b1;
        end
    end

    assign fl.alloc_ready  = (count >= CNT_W'(WIDTH));
    assign fl.empty        = (count == '0);
    assign fl.free_count   = count;
    assign fl.overflow_err = ovf_q;

    assign fire     = fl.alloc_ready && (|fl.alloc_req);
    assign rel_sum  = {1'b0, count} + (CNT_W+1)'(rel_n);
    assign rel_drop = (rel_sum > (CNT_W+1)'(DEPTH));
    assign rel_go   = !rel_drop && (rel_n != '0);
    assign pop_n    = fire   ? CNT_W'(alloc_n) : '0;
    assign push_n   = rel_go ? CNT_W'(rel_n)   : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= PREG_W'(NUM_ARCH + k);
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
            ovf_q <= 1'b0;
        end else begin
            if (fire) head <= head + PTR_W'(alloc_n);
            // An overflowing release group is dropped whole, never partially enqueued.
            if (rel_go) begin
                for (int i = 0; i < WIDTH; i++)
                    if (rel_ok[i]) mem[wr_idx[i]] <= rel_tag[i];
                tail <= tail + PTR_W'(rel_n);
            end
            if (rel_drop) ovf_q <= 1'b1;
            count <= count - pop_n + push_n;
        end
    end
endmodule
